leaderboard_readout: RTL and testbench

Reader side of the leaderboard's top-3 score registers. On request, the block snapshots the three ranked scores and user ids. It then converts each score from binary to 3-digit BCD with a sequential double-dabble. It emits one record per rank over a valid/ready stream to the display/text driver. The snapshot isolates the display from leaderboard updates that happen while a readout is in progress.

---
 rtl/leaderboard_pkg.sv | 40 ++++
 rtl/leaderboard_readout_bin2bcd_seq.sv | 66 ++++++
 rtl/leaderboard_readout.sv | 176 +++++++++++++++++
 tb/tb_leaderboard_readout.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaderboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : leaderboard_pkg
// Purpose  : Shared widths, FSM state type, rank codes and the double-dabble
//            step helper for the leaderboard readout path.
// Revision : 1.0 - initial release
// ============================================================================
package leaderboard_pkg;

    localparam int SCORE_W   = 8;
    localparam int ID_W      = 3;
    localparam int BCD_W     = 12;
    localparam int NUM_RANKS = 3;
    localparam int DD_STEPS  = 8;   // one step per binary score bit

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam logic [1:0] RANK_1 = 2'd1;
    localparam logic [1:0] RANK_2 = 2'd2;
    localparam logic [1:0] RANK_3 = 2'd3;

    // One double-dabble iteration on the {bcd[11:0], bin[7:0]} register:
    // correct every BCD nibble that would overflow on doubling, then shift.
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        for (int i = 0; i < 3; i++) begin
            if (t[8+4*i +: 4] >= 4'd5) begin
                t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/leaderboard_readout_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Iterative 8-bit binary to 3-digit BCD converter (double dabble),
//            one step per clock.
// Ports    : clk     - clock, rising edge
//            clr     - asynchronous active-low reset
//            load_i  - capture bin_i and restart the conversion
//            bin_i   - binary value to convert
//            bcd_o   - {hundreds, tens, ones}; valid once the 8th step is done
//            done_o  - high in the cycle whose clock edge completes step 8
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq (
    input  logic        clk,
    input  logic        clr,
    input  logic        load_i,
    input  logic [7:0]  bin_i,
    output logic [11:0] bcd_o,
    output logic        done_o
);
    import leaderboard_pkg::*;

    localparam logic [2:0] LAST_STEP = 3'(DD_STEPS - 1);

    logic [19:0] shift_q, shift_d;
    logic [2:0]  step_q, step_d;
    logic        run_q, run_d;

    always_comb begin
        shift_d = shift_q;
        step_d  = step_q;
        run_d   = run_q;
        done_o  = 1'b0;
        if (load_i) begin
            shift_d = {12'b0, bin_i};
            step_d  = 3'd0;
            run_d   = 1'b1;
        end else if (run_q) begin
            shift_d = dd_step(shift_q);
            step_d  = step_q + 3'd1;
            if (step_q == LAST_STEP) begin
                run_d  = 1'b0;
                done_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            shift_q <= '0;
            step_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            step_q  <= step_d;
            run_q   <= run_d;
        end
    end

    // The register freezes once the run ends, so the digits stay put while
    // the downstream consumer stalls.
    assign bcd_o = shift_q[19:8];

endmodule
`default_nettype wire

// File: rtl/leaderboard_readout.sv
`default_nettype none
// ============================================================================
// Module   : leaderboard_readout
// Purpose  : Snapshots the top-3 scores/ids on a trigger, converts each score
//            to BCD and streams one record per rank over valid/ready.
// Ports    : clk, clr (async active-low reset)
//            start            - one-cycle readout request
//            score1..3, id1..3- live leaderboard registers
//            busy             - readout in progress
//            rec_valid/ready  - record handshake
//            rec_rank/id/bcd/blank/last - record fields
//            done             - one-cycle pulse after the rank-3 handshake
// Revision : 1.0 - initial release
// ============================================================================
module leaderboard_readout #(
    parameter int SCORE_W     = leaderboard_pkg::SCORE_W,
    parameter int ID_W        = leaderboard_pkg::ID_W,
    parameter int REFRESH_CYC = 0
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [SCORE_W-1:0] score1,
    input  logic [SCORE_W-1:0] score2,
    input  logic [SCORE_W-1:0] score3,
    input  logic [ID_W-1:0]    id1,
    input  logic [ID_W-1:0]    id2,
    input  logic [ID_W-1:0]    id3,
    output logic               busy,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [1:0]         rec_rank,
    output logic [ID_W-1:0]    rec_id,
    output logic [11:0]        rec_bcd,
    output logic               rec_blank,
    output logic               rec_last,
    output logic               done
);
    import leaderboard_pkg::*;

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] snap_score_q [NUM_RANKS];
    logic [ID_W-1:0]    snap_id_q    [NUM_RANKS];
    logic [1:0]         rank_q;
    logic [ID_W-1:0]    rec_id_q;
    logic               rec_blank_q;
    logic               rec_last_q;
    logic               done_q;

    logic               refresh_tick;
    logic               trigger;
    logic               conv_load;
    logic [SCORE_W-1:0] conv_bin;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;
    logic               hs;
    logic [SCORE_W-1:0] next_score;
    logic [ID_W-1:0]    next_id;

    // Free-running refresh timer; it keeps counting while busy so the tick
    // cadence is independent of readout length (ticks while busy are lost).
    generate
        if (REFRESH_CYC > 0) begin : g_refresh
            localparam int CNT_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYC - 1);
            logic [CNT_W-1:0] cnt_q;
            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            assign refresh_tick = (cnt_q == CNT_LAST);
        end else begin : g_no_refresh
            assign refresh_tick = 1'b0;
        end
    endgenerate

    assign trigger = start | refresh_tick;

    // Next rank's data always comes from the snapshot, never the live inputs.
    assign next_score = (rank_q == RANK_1) ? snap_score_q[1] : snap_score_q[2];
    assign next_id    = (rank_q == RANK_1) ? snap_id_q[1]    : snap_id_q[2];

    bin2bcd_seq u_bin2bcd (
        .clk    (clk),
        .clr    (clr),
        .load_i (conv_load),
        .bin_i  (conv_bin),
        .bcd_o  (conv_bcd),
        .done_o (conv_done)
    );

    always_comb begin
        state_d   = state_q;
        conv_load = 1'b0;
        conv_bin  = score1;
        hs        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d   = CONV;
                    conv_load = 1'b1;
                    conv_bin  = score1;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (rec_ready) begin
                    hs = 1'b1;
                    if (rank_q == RANK_3) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = CONV;
                        conv_load = 1'b1;
                        conv_bin  = next_score;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= IDLE;
            rank_q      <= 2'd0;
            rec_id_q    <= '0;
            rec_blank_q <= 1'b0;
            rec_last_q  <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < NUM_RANKS; i++) begin
                snap_score_q[i] <= '0;
                snap_id_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= hs && (rank_q == RANK_3);
            if (state_q == IDLE && trigger) begin
                snap_score_q[0] <= score1;
                snap_score_q[1] <= score2;
                snap_score_q[2] <= score3;
                snap_id_q[0]    <= id1;
                snap_id_q[1]    <= id2;
                snap_id_q[2]    <= id3;
                rank_q          <= RANK_1;
                rec_id_q        <= id1;
                rec_blank_q     <= (score1 == '0);
                rec_last_q      <= 1'b0;
            end else if (hs && rank_q != RANK_3) begin
                rank_q      <= rank_q + 2'd1;
                rec_id_q    <= next_id;
                rec_blank_q <= (next_score == '0);
                rec_last_q  <= (rank_q == RANK_2);
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign rec_valid = (state_q == SEND);
    assign rec_rank  = rank_q;
    assign rec_id    = rec_id_q;
    assign rec_bcd   = conv_bcd;
    assign rec_blank = rec_blank_q;
    assign rec_last  = rec_last_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_leaderboard_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_leaderboard_readout
// Purpose  : Self-checking bench for leaderboard_readout: table of readout
//            vectors plus directed reset, reset-abort and refresh sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leaderboard_readout;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic        rec_ready = 1'b0;
    logic [7:0]  score1 = '0, score2 = '0, score3 = '0;
    logic [2:0]  id1 = '0, id2 = '0, id3 = '0;
    logic        busy, rec_valid, rec_blank, rec_last, done;
    logic [1:0]  rec_rank;
    logic [2:0]  rec_id;
    logic [11:0] rec_bcd;

    logic        start_r = 1'b0;
    logic        ready_r = 1'b1;
    logic        busy_r, rec_valid_r, rec_blank_r, rec_last_r, done_r;
    logic [1:0]  rec_rank_r;
    logic [2:0]  rec_id_r;
    logic [11:0] rec_bcd_r;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    leaderboard_readout #(.SCORE_W(8), .ID_W(3), .REFRESH_CYC(0)) dut (
        .clk(clk), .clr(clr), .start(start),
        .score1(score1), .score2(score2), .score3(score3),
        .id1(id1), .id2(id2), .id3(id3),
        .busy(busy), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_rank(rec_rank), .rec_id(rec_id), .rec_bcd(rec_bcd),
        .rec_blank(rec_blank), .rec_last(rec_last), .done(done)
    );

    leaderboard_readout #(.SCORE_W(8), .ID_W(3), .REFRESH_CYC(20)) dut_r (
        .clk(clk), .clr(clr), .start(start_r),
        .score1(score1), .score2(score2), .score3(score3),
        .id1(id1), .id2(id2), .id3(id3),
        .busy(busy_r), .rec_valid(rec_valid_r), .rec_ready(ready_r),
        .rec_rank(rec_rank_r), .rec_id(rec_id_r), .rec_bcd(rec_bcd_r),
        .rec_blank(rec_blank_r), .rec_last(rec_last_r), .done(done_r)
    );

    typedef struct {
        logic [23:0] s;      // {score1, score2, score3}
        logic [8:0]  id;     // {id1, id2, id3}
        logic [35:0] bcd;    // expected {rank1, rank2, rank3} BCD
        int          stall_rank;
        int          stall_n;
        bit          mutate;
        bit          extra;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference conversion by decimal arithmetic.
    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic vec_t mk(input int a, input int b, input int c,
                                input int ia, input int ib, input int ic,
                                input logic [35:0] bcd, input int sr, input int sn,
                                input bit mu, input bit ex);
        vec_t v;
        v.s = {8'(a), 8'(b), 8'(c)};
        v.id = {3'(ia), 3'(ib), 3'(ic)};
        v.bcd = bcd;
        v.stall_rank = sr;
        v.stall_n = sn;
        v.mutate = mu;
        v.extra = ex;
        return v;
    endfunction

    // Runs one start-triggered readout and checks each record, latency,
    // stall stability, done pulse and absence of extra records.
    task automatic run_readout(input vec_t v);
        logic [7:0]  sc  [3];
        logic [2:0]  ids [3];
        logic [11:0] bc  [3];
        int cyc, k, stall_left, hs_cyc;
        bit seen;
        logic [16:0] held;
        sc[0] = v.s[23:16]; sc[1] = v.s[15:8]; sc[2] = v.s[7:0];
        ids[0] = v.id[8:6]; ids[1] = v.id[5:3]; ids[2] = v.id[2:0];
        bc[0] = v.bcd[35:24]; bc[1] = v.bcd[23:12]; bc[2] = v.bcd[11:0];
        score1 = sc[0]; score2 = sc[1]; score3 = sc[2];
        id1 = ids[0]; id2 = ids[1]; id3 = ids[2];
        rec_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_on_trigger", busy, 1);
        cyc = 0; k = 0; seen = 0; stall_left = 0; hs_cyc = 0; held = '0;
        while (k < 3 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = v.extra && (cyc == 4 || cyc == 12);
            if (v.mutate && cyc == 3) begin
                score1 = 8'd3; score2 = 8'd9; score3 = 8'd77;
                id1 = 3'd0; id2 = 3'd7; id3 = 3'd4;
            end
            if (rec_valid) begin
                if (!seen) begin
                    if (k == 0) chk("first_latency", cyc, 8);
                    else        chk("next_latency", cyc, hs_cyc + 9);
                    chk("rec_rank", rec_rank, k + 1);
                    chk("rec_id", rec_id, ids[k]);
                    chk("rec_bcd", rec_bcd, bc[k]);
                    chk("rec_blank", rec_blank, sc[k] == 0);
                    chk("rec_last", rec_last, k == 2);
                    seen = 1;
                    held = {rec_rank, rec_id, rec_bcd};
                    stall_left = (k + 1 == v.stall_rank) ? v.stall_n : 0;
                end else begin
                    chk("stall_hold", {rec_rank, rec_id, rec_bcd}, held);
                end
                if (stall_left > 0) begin
                    rec_ready = 1'b0;
                    stall_left--;
                end else begin
                    rec_ready = 1'b1;
                    hs_cyc = cyc;
                    k++;
                    seen = 0;
                end
            end else begin
                rec_ready = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        if (k < 3) chk("readout_timeout", k, 3);
        @(negedge clk);
        rec_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_end", busy, 0);
        chk("valid_end", rec_valid, 0);
        @(negedge clk);
        chk("done_single", done, 0);
        repeat (10) @(negedge clk);
        chk("no_extra_record", {rec_valid, busy}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vq[$];
        int   rises[$];
        int   exp_rises[$];
        int   nrec, ndone, idle_from;
        bit   prev;

        vq.push_back(mk(255, 100,   7, 5, 2, 1, 36'h255_100_007, 0, 0, 0, 0));
        vq.push_back(mk(255, 100,   7, 5, 2, 1, 36'h255_100_007, 2, 5, 1, 0));
        vq.push_back(mk( 10,  99,   0, 3, 4, 6, 36'h010_099_000, 0, 0, 0, 1));
        vq.push_back(mk(  1,   9, 200, 7, 0, 2, 36'h001_009_200, 0, 0, 0, 0));
        vq.push_back(mk(128,  64,  32, 1, 6, 3, 36'h128_064_032, 3, 2, 0, 0));
        vq.push_back(mk(  0,   0,   0, 2, 2, 2, 36'h000_000_000, 1, 1, 0, 0));
        vq.push_back(mk(199, 250,   5, 4, 5, 6, 36'h199_250_005, 1, 3, 0, 1));
        for (int i = 0; i < 8; i++) begin
            int a, b, c;
            a = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
            b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
            c = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
            vq.push_back(mk(a, b, c, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 7)), {to_bcd(a), to_bcd(b), to_bcd(c)},
                            int'($urandom_range(1, 3)), int'($urandom_range(0, 4)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
        end

        // Reset held with start asserted: nothing may happen.
        #1 clr = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            score1 = 8'($urandom); score2 = 8'($urandom); score3 = 8'($urandom);
            id1 = 3'($urandom); id2 = 3'($urandom); id3 = 3'($urandom);
            chk("reset_outputs", {busy, rec_valid, done, rec_rank, rec_bcd}, 0);
        end
        start = 1'b0;
        clr = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_record_after_reset", {busy, rec_valid, done}, 0);

        // Table-driven readouts.
        for (int i = 0; i < vq.size(); i++) begin
            run_readout(vq[i]);
        end

        // Reset in the middle of the rank-2 conversion.
        score1 = vq[3].s[23:16]; score2 = vq[3].s[15:8]; score3 = vq[3].s[7:0];
        id1 = vq[3].id[8:6]; id2 = vq[3].id[5:3]; id3 = vq[3].id[2:0];
        rec_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (11) @(negedge clk);
        chk("midop_rank2_conv", {busy, rec_valid, rec_rank}, {1'b1, 1'b0, 2'd2});
        clr = 1'b0;
        #1;
        chk("midop_reset_outputs", {busy, rec_valid, done, rec_rank, rec_bcd}, 0);
        @(negedge clk);
        clr = 1'b1;
        rec_ready = 1'b0;
        repeat (12) @(negedge clk);
        chk("midop_no_record", {busy, rec_valid}, 0);
        run_readout(vq[4]);

        // Refresh instance: start coincides with the first tick.
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        prev = 0; nrec = 0; ndone = 0;
        for (int e = 1; e <= 100; e++) begin
            @(negedge clk);
            if (busy_r && !prev) rises.push_back(e);
            prev = busy_r;
            if (e < 60) begin
                if (rec_valid_r) nrec++;
                if (done_r) ndone++;
            end
            start_r = (e == 19);
        end
        start_r = 1'b0;
        // Ticks every 20 edges; a readout keeps the block busy for 28 edges.
        idle_from = 0;
        for (int t = 20; t <= 100; t += 20) begin
            if (t >= idle_from) begin
                exp_rises.push_back(t);
                idle_from = t + 3 * 9 + 1;
            end
        end
        chk("refresh_readout_count", rises.size(), exp_rises.size());
        for (int i = 0; i < exp_rises.size() && i < rises.size(); i++) begin
            chk("refresh_start_edge", rises[i], exp_rises[i]);
        end
        chk("refresh_single_records", nrec, 3);
        chk("refresh_single_done", ndone, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
